alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one opcode/operand set at a time, holds it on the
// ALU inputs for the number of cycles that opcode needs to settle, then captures the result.
module alu_op_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic        i_clock,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [4:0]  i_op_in,
  input  logic [31:0] i_ra_in,
  input  logic [31:0] i_rb_in,
  output logic [4:0]  o_alu_opcode,
  output logic [31:0] o_alu_ra,
  output logic [31:0] o_alu_rb,
  input  logic [31:0] i_alu_zhi,
  input  logic [31:0] i_alu_zlo,
  output logic [31:0] o_zhi,
  output logic [31:0] o_zlo,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [4:0] OpMul   = 5'b01110;
  localparam logic [4:0] OpDiv   = 5'b01111;
  // Counter is loaded with N-1 so that EXEC lasts exactly N cycles.
  localparam logic [3:0] MulLoad = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DivLoad = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [4:0]  r_opcode;
  logic [31:0] r_ra;
  logic [31:0] r_rb;
  logic [31:0] r_zhi;
  logic [31:0] r_zlo;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_legal;
  logic [3:0]  w_load;

  // Decode opcode legality and the settle-count preload for the requested op.
  always_comb begin
    w_legal = 1'b0;
    w_load  = 4'd0;
    case (i_op_in)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
      5'b01001, 5'b01010, 5'b10000, 5'b10001: w_legal = 1'b1;
      OpMul: begin
        w_legal = 1'b1;
        w_load  = MulLoad;
      end
      OpDiv: begin
        w_legal = 1'b1;
        w_load  = DivLoad;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Sequencer FSM with registered outputs; clear aborts any operation immediately.
  always_ff @(posedge i_clock or negedge i_clear) begin
    if (!i_clear) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_opcode <= 5'd0;
      r_ra     <= 32'd0;
      r_rb     <= 32'd0;
      r_zhi    <= 32'd0;
      r_zlo    <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_busy <= 1'b1;
            if (!w_legal) begin
              // Illegal opcode: nothing latched, report straight away.
              r_state <= StDone;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_opcode <= i_op_in;
              r_ra     <= i_ra_in;
              r_rb     <= i_rb_in;
              if (i_op_in == OpDiv && i_rb_in == 32'd0) begin
                r_state <= StDone;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end else begin
                r_cnt   <= w_load;
                r_state <= StExec;
              end
            end
          end
        end
        StExec: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_zhi   <= i_alu_zhi;
            r_zlo   <= i_alu_zlo;
            r_state <= StDone;
            r_done  <= 1'b1;
            r_err   <= 1'b0;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_alu_opcode = r_opcode;
  assign o_alu_ra     = r_ra;
  assign o_alu_rb     = r_rb;
  assign o_zhi        = r_zhi;
  assign o_zlo        = r_zlo;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
